spi_audio_rx: RTL and testbench

SPI_AUDIO_RX -- requirements
Module: spi_audio_rx

---
 rtl/spi_audio_pkg.sv | 19 +
 rtl/audio_fifo.sv | 53 +++++
 rtl/spi_audio_rx.sv | 145 ++++++++++++++
 tb/tb_spi_audio_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_audio_pkg.sv
// rtl/spi_audio_pkg.sv - shared types and SPI mode constants for the audio receiver
package spi_audio_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        RECEIVING = 1'b1
    } state_t;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;

    // Modes 0 and 3 latch data on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic bit sample_on_rising(input int mode);
        return (mode == SPI_MODE0) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/audio_fifo.sv
// rtl/audio_fifo.sv - first-word-fall-through sample FIFO with drop indication
module audio_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                   clk_25mhz,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   drop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             accept;

    assign full      = (level == (AW+1)'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign head      = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_audio_rx.sv
// rtl/spi_audio_rx.sv - SPI slave that deserialises interleaved audio samples into a FIFO
module spi_audio_rx
    import spi_audio_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int SPI_MODE   = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                                   clk_25mhz,
    input  logic                                   reset,
    input  logic                                   sclk_in,
    input  logic                                   mosi_in,
    input  logic                                   active,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
    output logic                                   overrun,
    output logic                                   frame_err,
    input  logic                                   clear_err
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam bit SAMPLE_RISING = sample_on_rising(SPI_MODE);

    logic [1:0] sclk_sync, mosi_sync, active_sync;
    logic       sclk_d, active_d;
    logic       sample_edge, active_rise, active_fall;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            active_sync <= '0;
            sclk_d      <= 1'b0;
            active_d    <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[0], sclk_in};
            mosi_sync   <= {mosi_sync[0], mosi_in};
            active_sync <= {active_sync[0], active};
            sclk_d      <= sclk_sync[1];
            active_d    <= active_sync[1];
        end
    end

    assign sample_edge = SAMPLE_RISING ? (sclk_sync[1] && !sclk_d) : (!sclk_sync[1] && sclk_d);
    assign active_rise = active_sync[1] && !active_d;
    assign active_fall = !active_sync[1] && active_d;

    state_t             state, state_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]  shift_reg, shift_n, shifted;
    logic [CH_W-1:0]    ch_idx, ch_n;
    logic               push, frame_err_set, drop;

    assign shifted = (MSB_FIRST != 0) ? {shift_reg[DATA_W-2:0], mosi_sync[1]}
                                      : {mosi_sync[1], shift_reg[DATA_W-1:1]};

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ch_idx    <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            ch_idx    <= ch_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift_reg;
        ch_n          = ch_idx;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (active_rise) begin
                    state_n   = RECEIVING;
                    bit_cnt_n = '0;
                    shift_n   = '0;
                    ch_n      = '0;
                end
            end
            RECEIVING: begin
                // End of frame takes priority over a coincident sample edge.
                if (active_fall) begin
                    state_n       = IDLE;
                    frame_err_set = (bit_cnt != '0);
                    bit_cnt_n     = '0;
                end else if (sample_edge) begin
                    shift_n = shifted;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        push      = 1'b1;
                        bit_cnt_n = '0;
                        ch_n      = (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [CH_W+DATA_W-1:0] head;

    audio_fifo #(
        .WIDTH (CH_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .push      (push),
        .push_data ({ch_idx, shifted}),
        .drop      (drop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .head      (head),
        .level     (fifo_level)
    );

    assign out_data = head[DATA_W-1:0];
    assign out_ch   = head[DATA_W +: CH_W];

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop)           overrun <= 1'b1;
            else if (clear_err) overrun <= 1'b0;
            if (frame_err_set)  frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_audio_rx.sv
// tb/tb_spi_audio_rx.sv - randomized and directed checks of spi_audio_rx against a frame-level model
module tb_spi_audio_rx;
    localparam int HALF = 4;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic        sclk, mosi, clear_err;
    logic        act  [3];
    logic        ordy [3];
    logic        ov   [3];
    logic [15:0] od   [3];
    logic        oc   [3];
    logic [3:0]  lvl  [3];
    logic        orun [3];
    logic        ferr [3];

    always #20 clk_25mhz = ~clk_25mhz;

    spi_audio_rx #(.DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(8), .SPI_MODE(0), .MSB_FIRST(1)) dut_a (
        .clk_25mhz(clk_25mhz), .reset(reset), .sclk_in(sclk), .mosi_in(mosi), .active(act[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ch(oc[0]),
        .fifo_level(lvl[0]), .overrun(orun[0]), .frame_err(ferr[0]), .clear_err(clear_err));

    spi_audio_rx #(.DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(8), .SPI_MODE(0), .MSB_FIRST(0)) dut_b (
        .clk_25mhz(clk_25mhz), .reset(reset), .sclk_in(sclk), .mosi_in(mosi), .active(act[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ch(oc[1]),
        .fifo_level(lvl[1]), .overrun(orun[1]), .frame_err(ferr[1]), .clear_err(clear_err));

    spi_audio_rx #(.DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(8), .SPI_MODE(1), .MSB_FIRST(1)) dut_c (
        .clk_25mhz(clk_25mhz), .reset(reset), .sclk_in(sclk), .mosi_in(mosi), .active(act[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_ch(oc[2]),
        .fifo_level(lvl[2]), .overrun(orun[2]), .frame_err(ferr[2]), .clear_err(clear_err));

    int          total  = 0;
    int          passed = 0;
    logic [16:0] mq [$];
    logic [15:0] wbuf [16];
    logic        exp_orun = 1'b0;
    logic        exp_ferr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_25mhz);
    endtask

    task automatic drive_bit(input logic b, input bit mode1);
        if (!mode1) begin
            mosi = b; wait_clk(HALF); sclk = 1'b1; wait_clk(HALF); sclk = 1'b0;
        end else begin
            sclk = 1'b1; mosi = b; wait_clk(HALF); sclk = 1'b0; wait_clk(HALF);
        end
    endtask

    task automatic wait_valid(input int idx, input string tag);
        int c = 0;
        while (ov[idx] !== 1'b1 && c < 64) begin
            @(negedge clk_25mhz);
            c++;
        end
        check(tag, 32'(ov[idx]), 32'd1);
    endtask

    task automatic check_reset_outputs(input int idx, input string tag);
        check({tag, "_valid"}, 32'(ov[idx]), 32'd0);
        check({tag, "_data"}, 32'(od[idx]), 32'd0);
        check({tag, "_ch"}, 32'(oc[idx]), 32'd0);
        check({tag, "_level"}, 32'(lvl[idx]), 32'd0);
        check({tag, "_overrun"}, 32'(orun[idx]), 32'd0);
        check({tag, "_frame_err"}, 32'(ferr[idx]), 32'd0);
    endtask

    // Frame on DUT A: nw whole words from wbuf, then extra trailing bits.
    // Model: word k goes to channel k mod 2; a full 8-entry FIFO drops the word.
    task automatic a_frame(input int nw, input int extra);
        act[0] = 1'b1;
        wait_clk(4);
        for (int k = 0; k < nw; k++) begin
            logic [15:0] w;
            w = wbuf[k];
            for (int i = 15; i >= 0; i--) drive_bit(w[i], 1'b0);
            if (mq.size() < 8) mq.push_back({((k % 2) == 1), w});
            else exp_orun = 1'b1;
        end
        for (int i = 0; i < extra; i++) drive_bit(1'b1, 1'b0);
        if ((extra % 16) != 0) exp_ferr = 1'b1;
        wait_clk(4);
        act[0] = 1'b0;
        wait_clk(4);
    endtask

    task automatic drain_a(input string tag);
        while (mq.size() > 0) begin
            logic [16:0] e;
            e = mq.pop_front();
            wait_valid(0, {tag, "_valid"});
            check({tag, "_ch"}, 32'(oc[0]), 32'(e[16]));
            check({tag, "_data"}, 32'(od[0]), 32'(e[15:0]));
            wait_clk(1);
            check({tag, "_hold"}, 32'(od[0]), 32'(e[15:0]));
            ordy[0] = 1'b1;
            wait_clk(1);
            ordy[0] = 1'b0;
        end
        check({tag, "_empty"}, 32'(lvl[0]), 32'd0);
    endtask

    task automatic pulse_clear;
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        exp_orun = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; clear_err = 1'b0;
        for (int i = 0; i < 3; i++) begin act[i] = 1'b0; ordy[i] = 1'b0; end
        wait_clk(3);
        check_reset_outputs(0, "rst_a");
        check("rst_b_valid", 32'(ov[1]), 32'd0);
        check("rst_c_valid", 32'(ov[2]), 32'd0);
        reset = 1'b0;
        wait_clk(4);

        // Two-word frame with latency of out_valid after the 16th sample edge.
        act[0] = 1'b1;
        wait_clk(4);
        w = 16'hA5C3;
        for (int i = 15; i >= 1; i--) drive_bit(w[i], 1'b0);
        mosi = w[0];
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(2);
        check("lat_not_yet", 32'(ov[0]), 32'd0);
        wait_clk(1);
        check("lat_valid", 32'(ov[0]), 32'd1);
        wait_clk(HALF - 3);
        sclk = 1'b0;
        w = 16'h1234;
        for (int i = 15; i >= 0; i--) drive_bit(w[i], 1'b0);
        wait_clk(4);
        act[0] = 1'b0;
        wait_clk(4);
        mq.push_back({1'b0, 16'hA5C3});
        mq.push_back({1'b1, 16'h1234});
        check("two_word_level", 32'(lvl[0]), 32'd2);
        drain_a("two_word");
        check("two_word_ferr", 32'(ferr[0]), 32'd0);

        // LSB-first receiver.
        act[1] = 1'b1;
        wait_clk(4);
        w = 16'h0001;
        for (int i = 0; i < 16; i++) drive_bit(w[i], 1'b0);
        wait_clk(4);
        act[1] = 1'b0;
        wait_valid(1, "lsb_valid");
        check("lsb_data", 32'(od[1]), 32'h0001);
        check("lsb_ch", 32'(oc[1]), 32'd0);

        // Mode 1 receiver, data changes on rising SCLK.
        act[2] = 1'b1;
        wait_clk(4);
        w = 16'hBEEF;
        for (int i = 15; i >= 0; i--) drive_bit(w[i], 1'b1);
        wait_clk(4);
        act[2] = 1'b0;
        wait_valid(2, "mode1_valid");
        check("mode1_data", 32'(od[2]), 32'hBEEF);
        check("mode1_ch", 32'(oc[2]), 32'd0);

        // Truncated frame of 9 bits, then a clean frame.
        a_frame(0, 9);
        check("trunc_level", 32'(lvl[0]), 32'd0);
        check("trunc_valid", 32'(ov[0]), 32'd0);
        check("trunc_ferr", 32'(ferr[0]), 32'(exp_ferr));
        wbuf[0] = 16'hFFFF;
        a_frame(1, 0);
        drain_a("after_trunc");
        check("ferr_sticky", 32'(ferr[0]), 32'd1);
        pulse_clear();
        check("ferr_cleared", 32'(ferr[0]), 32'(exp_ferr));

        // Nine words into an 8-deep FIFO with no consumer.
        for (int k = 0; k < 9; k++) wbuf[k] = 16'(k + 1);
        a_frame(9, 0);
        check("ovr_level", 32'(lvl[0]), 32'd8);
        check("ovr_flag", 32'(orun[0]), 32'(exp_orun));
        drain_a("ovr_drain");
        pulse_clear();
        check("ovr_cleared", 32'(orun[0]), 32'(exp_orun));

        // Randomized frames.
        for (int f = 0; f < 3; f++) begin
            int nw;
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++) wbuf[k] = 16'($urandom);
            a_frame(nw, 0);
            check("rand_level", 32'(lvl[0]), 32'(mq.size()));
            drain_a("rand");
            check("rand_ferr", 32'(ferr[0]), 32'(exp_ferr));
            check("rand_orun", 32'(orun[0]), 32'(exp_orun));
        end

        // Reset in the middle of a word.
        act[0] = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 7; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        reset = 1'b1;
        act[0] = 1'b0;
        wait_clk(2);
        check_reset_outputs(0, "midrst");
        reset = 1'b0;
        wait_clk(4);
        wbuf[0] = 16'h5A5A;
        a_frame(1, 0);
        check("post_rst_ferr", 32'(ferr[0]), 32'd0);
        drain_a("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
